// File: rtl/inst_loader.sv
// Boot loader for the 512x32 instruction memory: parses a framed byte stream,
// writes big-endian words from address 0 upward and releases the core on a good checksum.
module inst_loader #(
    parameter int          ADDR_W    = 9,
    parameter int          MAX_WORDS = 512,
    parameter logic [7:0]  MAGIC     = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              start,
    output logic              im_wen,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_rst_n,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state, state_next;
    logic [7:0]        len_hi;
    logic [15:0]       len;
    logic [1:0]        byte_idx;
    logic [ADDR_W-1:0] word_idx;
    logic [7:0]        csum;
    logic [23:0]       shift;

    logic        xfer;
    logic [15:0] len_in;
    logic        last_word;

    assign xfer      = rx_valid & rx_ready;
    assign len_in    = {len_hi, rx_data};
    assign last_word = (32'(word_idx) == 32'(len) - 32'd1);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of statement order.
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: default assigned first so no path through the case leaves
        // state_next unassigned, which would infer a latch.
        state_next = state;
        case (state)
            S_IDLE:   if (xfer && rx_data == MAGIC) state_next = S_LEN_HI;
            S_LEN_HI: if (xfer) state_next = S_LEN_LO;
            S_LEN_LO: begin
                if (xfer) begin
                    if (32'(len_in) > 32'(MAX_WORDS)) state_next = S_ERR;
                    else if (len_in == 16'd0)         state_next = S_CSUM;
                    else                              state_next = S_DATA;
                end
            end
            S_DATA:   if (xfer && byte_idx == 2'd3 && last_word) state_next = S_CSUM;
            S_CSUM:   if (xfer) state_next = (rx_data == csum) ? S_DONE : S_ERR;
            S_DONE,
            S_ERR:    if (start) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Status outputs are registered from state_next so they change on the same
    // edge as the state they describe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_ready  <= 1'b0;
            im_wen    <= 1'b0;
            im_addr   <= '0;
            im_wdata  <= '0;
            cpu_rst_n <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            len_hi    <= '0;
            len       <= '0;
            byte_idx  <= '0;
            word_idx  <= '0;
            csum      <= '0;
            shift     <= '0;
        end else begin
            rx_ready  <= !(state_next == S_DONE || state_next == S_ERR);
            done      <= (state_next == S_DONE);
            cpu_rst_n <= (state_next == S_DONE);
            error     <= (state_next == S_ERR);
            im_wen    <= 1'b0;

            case (state)
                S_LEN_HI: if (xfer) len_hi <= rx_data;
                S_LEN_LO: begin
                    if (xfer) begin
                        len      <= len_in;
                        csum     <= '0;
                        byte_idx <= '0;
                        word_idx <= '0;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        shift    <= {shift[15:0], rx_data};
                        csum     <= csum ^ rx_data;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            im_wen   <= 1'b1;
                            im_addr  <= word_idx;
                            im_wdata <= {shift, rx_data};
                            if (!last_word) word_idx <= word_idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: framing, checksum, length limits, flow control and reset.
module tb_inst_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        start = 1'b0;
    logic        im_wen;
    logic [8:0]  im_addr;
    logic [31:0] im_wdata;
    logic        cpu_rst_n;
    logic        done;
    logic        error;

    int errors = 0;
    int checks = 0;

    logic [7:0]  frame_q[$];
    logic [8:0]  wr_addr[$];
    logic [31:0] wr_data[$];

    inst_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .start     (start),
        .im_wen    (im_wen),
        .im_addr   (im_addr),
        .im_wdata  (im_wdata),
        .cpu_rst_n (cpu_rst_n),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    // Record every write pulse, one entry per cycle im_wen is high.
    always @(negedge clk) begin
        if (im_wen === 1'b1) begin
            wr_addr.push_back(im_addr);
            wr_data.push_back(im_wdata);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        while (rx_ready !== 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (rx_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: rx_ready=%b required 1 for byte %h", rx_ready, b);
        end else begin
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input int gap);
        @(posedge clk);
        #1;
        foreach (frame_q[i]) send_byte(frame_q[i], gap);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic clear_writes();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic load_good_frame(input logic [7:0] last);
        frame_q = '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                    8'hAC, 8'h08, 8'h00, 8'h00, last};
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if (rx_ready !== 1'b0)   begin errors++; $display("FAIL reset_rx_ready: got %b want 0", rx_ready); end
        checks++; if (im_wen !== 1'b0)     begin errors++; $display("FAIL reset_im_wen: got %b want 0", im_wen); end
        checks++; if (im_addr !== 9'd0)    begin errors++; $display("FAIL reset_im_addr: got %h want 0", im_addr); end
        checks++; if (im_wdata !== 32'd0)  begin errors++; $display("FAIL reset_im_wdata: got %h want 0", im_wdata); end
        checks++; if (cpu_rst_n !== 1'b0)  begin errors++; $display("FAIL reset_cpu_rst_n: got %b want 0", cpu_rst_n); end
        checks++; if (done !== 1'b0)       begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (error !== 1'b0)      begin errors++; $display("FAIL reset_error: got %b want 0", error); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (rx_ready !== 1'b0)   begin errors++; $display("FAIL release_rx_ready_first: got %b want 0", rx_ready); end
        @(negedge clk);
        checks++; if (rx_ready !== 1'b1)   begin errors++; $display("FAIL release_rx_ready_second: got %b want 1", rx_ready); end
        idle(1);
    endtask

    task automatic test_good_frame();
        logic [8:0]  exp_a[2];
        logic [31:0] exp_d[2];
        exp_a = '{9'd0, 9'd1};
        exp_d = '{32'h20080005, 32'hAC080000};
        clear_writes();
        load_good_frame(8'h89);
        send_frame(0);
        idle(2);
        @(negedge clk);
        checks++; if (wr_addr.size() != 2) begin errors++; $display("FAIL good_write_count: got %0d want 2", wr_addr.size()); end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (i >= wr_addr.size() || wr_addr[i] !== exp_a[i] || wr_data[i] !== exp_d[i]) begin
                errors++;
                $display("FAIL good_write_%0d: got %h/%h want %h/%h", i,
                         (i < wr_addr.size()) ? wr_addr[i] : 9'hxxx,
                         (i < wr_data.size()) ? wr_data[i] : 32'hxxxxxxxx, exp_a[i], exp_d[i]);
            end
        end
        checks++; if (done !== 1'b1)      begin errors++; $display("FAIL good_done: got %b want 1", done); end
        checks++; if (cpu_rst_n !== 1'b1) begin errors++; $display("FAIL good_cpu_rst_n: got %b want 1", cpu_rst_n); end
        checks++; if (error !== 1'b0)     begin errors++; $display("FAIL good_error: got %b want 0", error); end
        checks++; if (rx_ready !== 1'b0)  begin errors++; $display("FAIL good_rx_ready: got %b want 0", rx_ready); end
        checks++; if (im_addr !== 9'd1 || im_wdata !== 32'hAC080000) begin
            errors++; $display("FAIL good_hold: got %h/%h want 001/ac080000", im_addr, im_wdata);
        end
        pulse_start();
        @(negedge clk);
        checks++; if (done !== 1'b0 || cpu_rst_n !== 1'b0 || rx_ready !== 1'b1) begin
            errors++; $display("FAIL good_rearm: done=%b cpu_rst_n=%b rx_ready=%b want 0/0/1", done, cpu_rst_n, rx_ready);
        end
    endtask

    task automatic test_bad_checksum();
        clear_writes();
        load_good_frame(8'h88);
        send_frame(0);
        idle(2);
        @(negedge clk);
        checks++; if (wr_addr.size() != 2) begin errors++; $display("FAIL bad_write_count: got %0d want 2", wr_addr.size()); end
        checks++; if (error !== 1'b1)      begin errors++; $display("FAIL bad_error: got %b want 1", error); end
        checks++; if (done !== 1'b0)       begin errors++; $display("FAIL bad_done: got %b want 0", done); end
        checks++; if (cpu_rst_n !== 1'b0)  begin errors++; $display("FAIL bad_cpu_rst_n: got %b want 0", cpu_rst_n); end
        checks++; if (rx_ready !== 1'b0)   begin errors++; $display("FAIL bad_rx_ready: got %b want 0", rx_ready); end
        pulse_start();
        @(negedge clk);
        checks++; if (error !== 1'b0)      begin errors++; $display("FAIL bad_start_error: got %b want 0", error); end
        checks++; if (rx_ready !== 1'b1)   begin errors++; $display("FAIL bad_start_rx_ready: got %b want 1", rx_ready); end
    endtask

    task automatic test_oversize();
        clear_writes();
        frame_q = '{8'hA5, 8'h02, 8'h01};
        send_frame(0);
        idle(1);
        @(negedge clk);
        checks++; if (error !== 1'b1)      begin errors++; $display("FAIL oversize_error: got %b want 1", error); end
        checks++; if (wr_addr.size() != 0) begin errors++; $display("FAIL oversize_writes: got %0d want 0", wr_addr.size()); end
        checks++; if (cpu_rst_n !== 1'b0)  begin errors++; $display("FAIL oversize_cpu_rst_n: got %b want 0", cpu_rst_n); end
        pulse_start();
    endtask

    task automatic test_zero_length();
        clear_writes();
        frame_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_frame(0);
        idle(1);
        @(negedge clk);
        checks++; if (done !== 1'b1)       begin errors++; $display("FAIL zero_done: got %b want 1", done); end
        checks++; if (error !== 1'b0)      begin errors++; $display("FAIL zero_error: got %b want 0", error); end
        checks++; if (wr_addr.size() != 0) begin errors++; $display("FAIL zero_writes: got %0d want 0", wr_addr.size()); end
        pulse_start();
    endtask

    task automatic test_junk_flow();
        logic [31:0] exp_d[2];
        exp_d = '{32'h20080005, 32'hAC080000};
        clear_writes();
        frame_q = '{8'h3C, 8'hFF, 8'hA5, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                    8'hAC, 8'h08, 8'h00, 8'h00, 8'h89};
        send_frame(3);
        idle(1);
        @(negedge clk);
        checks++; if (wr_addr.size() != 2) begin errors++; $display("FAIL junk_write_count: got %0d want 2", wr_addr.size()); end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (i >= wr_addr.size() || wr_addr[i] !== 9'(i) || wr_data[i] !== exp_d[i]) begin
                errors++;
                $display("FAIL junk_write_%0d: got %h/%h want %h/%h", i,
                         (i < wr_addr.size()) ? wr_addr[i] : 9'hxxx,
                         (i < wr_data.size()) ? wr_data[i] : 32'hxxxxxxxx, 9'(i), exp_d[i]);
            end
        end
        checks++; if (done !== 1'b1 || cpu_rst_n !== 1'b1) begin
            errors++; $display("FAIL junk_done: done=%b cpu_rst_n=%b want 1/1", done, cpu_rst_n);
        end
        pulse_start();
    endtask

    task automatic test_max_frame();
        logic [7:0]  c;
        logic [15:0] v;
        int          bad;
        c = 8'h00;
        bad = 0;
        clear_writes();
        frame_q = '{8'hA5, 8'h02, 8'h00};
        for (int i = 0; i < 512; i++) begin
            v = 16'(i);
            frame_q.push_back(8'h00);
            frame_q.push_back(8'h00);
            frame_q.push_back(v[15:8]);
            frame_q.push_back(v[7:0]);
            c = c ^ v[15:8] ^ v[7:0];
        end
        frame_q.push_back(c);
        send_frame(0);
        idle(1);
        @(negedge clk);
        checks++; if (wr_addr.size() != 512) begin errors++; $display("FAIL max_write_count: got %0d want 512", wr_addr.size()); end
        for (int i = 0; i < wr_addr.size() && i < 512; i++)
            if (wr_addr[i] !== 9'(i) || wr_data[i] !== 32'(i)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL max_entries: got %0d bad entries want 0", bad); end
        checks++; if (im_addr !== 9'd511 || im_wdata !== 32'h000001FF) begin
            errors++; $display("FAIL max_last_write: got %h/%h want 1ff/000001ff", im_addr, im_wdata);
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL max_done: got %b want 1", done); end
        pulse_start();
    endtask

    task automatic test_mid_reset();
        clear_writes();
        frame_q = '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08};
        send_frame(0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (im_wen !== 1'b0 || im_addr !== 9'd0 || im_wdata !== 32'd0) begin
            errors++; $display("FAIL midrst_im: got %b/%h/%h want 0/000/00000000", im_wen, im_addr, im_wdata);
        end
        checks++; if (rx_ready !== 1'b0 || done !== 1'b0 || error !== 1'b0 || cpu_rst_n !== 1'b0) begin
            errors++; $display("FAIL midrst_status: rx_ready=%b done=%b error=%b cpu_rst_n=%b want 0/0/0/0",
                               rx_ready, done, error, cpu_rst_n);
        end
        frame_q = '{8'h00, 8'h00, 8'h89};
        send_frame(0);
        idle(4);
        @(negedge clk);
        checks++; if (wr_addr.size() != 1) begin errors++; $display("FAIL midrst_writes: got %0d want 1", wr_addr.size()); end
        checks++; if (done !== 1'b0)       begin errors++; $display("FAIL midrst_done: got %b want 0", done); end
        clear_writes();
        load_good_frame(8'h89);
        send_frame(0);
        idle(1);
        @(negedge clk);
        checks++; if (wr_addr.size() != 2) begin errors++; $display("FAIL midrst_reload_count: got %0d want 2", wr_addr.size()); end
        checks++; if (wr_data.size() == 2 && (wr_data[0] !== 32'h20080005 || wr_data[1] !== 32'hAC080000)) begin
            errors++; $display("FAIL midrst_reload_data: got %h/%h want 20080005/ac080000", wr_data[0], wr_data[1]);
        end
        checks++; if (done !== 1'b1 || cpu_rst_n !== 1'b1) begin
            errors++; $display("FAIL midrst_reload_done: done=%b cpu_rst_n=%b want 1/1", done, cpu_rst_n);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_oversize();
        test_zero_length();
        test_junk_flow();
        test_max_frame();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
